// File: rtl/mips_muldiv_alu.sv
// mips_muldiv_alu: registered ALU plus iterative MULTU/DIVU into HI/LO.
// Define SIGNED_MULDIV_EN to add signed MULT (1110) and DIV (1111).
module mips_muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             is_mul, is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] sc_res;

  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] m_acc, m_quo;
  logic [WIDTH:0]   d_sh;
  logic             d_ge;
  logic [WIDTH-1:0] d_acc, d_quo;
  logic [WIDTH-1:0] fin_mhi, fin_mlo;
  logic [WIDTH-1:0] fin_dhi, fin_dlo;

`ifdef SIGNED_MULDIV_EN
  logic a_neg, b_neg;
  logic neg_p_q, neg_p_d;
  logic neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] prod_s;

  assign is_mul = (ALUControl == 4'b1100) || (ALUControl == 4'b1110);
  assign is_div = (ALUControl == 4'b1101) || (ALUControl == 4'b1111);
  assign a_neg  = ALUControl[1] & SrcA[WIDTH-1];
  assign b_neg  = ALUControl[1] & SrcB[WIDTH-1];
  assign mag_a  = a_neg ? -SrcA : SrcA;
  assign mag_b  = b_neg ? -SrcB : SrcB;

  // Iterators work on magnitudes; signs are restored on the final step.
  always_comb begin
    prod_s = {m_acc, m_quo};
    if (neg_p_q) prod_s = -{m_acc, m_quo};
    fin_mhi = prod_s[2*WIDTH-1:WIDTH];
    fin_mlo = prod_s[WIDTH-1:0];
    fin_dlo = neg_p_q ? -d_quo : d_quo;
    fin_dhi = neg_r_q ? -d_acc : d_acc;
  end
`else
  assign is_mul  = (ALUControl == 4'b1100);
  assign is_div  = (ALUControl == 4'b1101);
  assign mag_a   = SrcA;
  assign mag_b   = SrcB;
  assign fin_mhi = m_acc;
  assign fin_mlo = m_quo;
  assign fin_dhi = d_acc;
  assign fin_dlo = d_quo;
`endif

  assign sh = SrcB[SW-1:0];

  always_comb begin
    sc_res = '0;
    case (ALUControl)
      4'b0000: sc_res = SrcA & SrcB;
      4'b0001: sc_res = SrcA | SrcB;
      4'b0010: sc_res = SrcA + SrcB;
      4'b0011: sc_res = SrcA ^ SrcB;
      4'b0100: sc_res = ~(SrcA | SrcB);
      4'b0101: sc_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      4'b0110: sc_res = SrcA - SrcB;
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'b1000: sc_res = SrcA << sh;
      4'b1001: sc_res = SrcA >> sh;
      4'b1010: sc_res = $signed(SrcA) >>> sh;
      default: sc_res = '0;
    endcase
  end

  // Shift-add multiply: acc:quo holds partial product above remaining multiplier.
  assign m_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
  assign m_acc = m_sum[WIDTH:1];
  assign m_quo = {m_sum[0], quo_q[WIDTH-1:1]};

  // Restoring divide: acc is the partial remainder, quo shifts dividend out.
  assign d_sh  = {acc_q, quo_q[WIDTH-1]};
  assign d_ge  = d_sh >= {1'b0, opb_q};
  assign d_acc = d_ge ? (d_sh[WIDTH-1:0] - opb_q) : d_sh[WIDTH-1:0];
  assign d_quo = {quo_q[WIDTH-2:0], d_ge};

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
`ifdef SIGNED_MULDIV_EN
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          dz_d = 1'b0;
`ifdef SIGNED_MULDIV_EN
          neg_p_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
`endif
          if (is_mul) begin
            state_d = S_MUL;
            acc_d   = '0;
            quo_d   = mag_b;
            opb_d   = mag_a;
            cnt_d   = CW'(WIDTH);
          end else if (is_div) begin
            if (SrcB == '0) begin
              state_d = S_DONE;
              lo_d    = '1;
              hi_d    = SrcA;
              dz_d    = 1'b1;
            end else begin
              state_d = S_DIV;
              acc_d   = '0;
              quo_d   = mag_a;
              opb_d   = mag_b;
              cnt_d   = CW'(WIDTH);
            end
          end else begin
            state_d = S_DONE;
            res_d   = sc_res;
          end
        end
      end
      S_MUL: begin
        acc_d = m_acc;
        quo_d = m_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          hi_d    = fin_mhi;
          lo_d    = fin_mlo;
        end
      end
      S_DIV: begin
        acc_d = d_acc;
        quo_d = d_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          hi_d    = fin_dhi;
          lo_d    = fin_dlo;
        end
      end
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef SIGNED_MULDIV_EN
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign ALUResult = res_q;
  assign Zero      = (res_q == '0);
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// tb_mips_muldiv_alu: random + directed ops against a queue-based
// arithmetic reference; monitor pops on every Done pulse.
module tb_mips_muldiv_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [3:0]   ALUControl = '0;
  logic [W-1:0] ALUResult, Hi, Lo;
  logic         Zero, Busy, Done, DivZero;

  mips_muldiv_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .Start(Start),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .ALUControl(ALUControl),
    .ALUResult(ALUResult),
    .Zero(Zero),
    .Hi(Hi),
    .Lo(Lo),
    .Busy(Busy),
    .Done(Done),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;
  logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit is_mul(input logic [3:0] op);
`ifdef SIGNED_MULDIV_EN
    return op == 4'd12 || op == 4'd14;
`else
    return op == 4'd12;
`endif
  endfunction

  function automatic bit is_div(input logic [3:0] op);
`ifdef SIGNED_MULDIV_EN
    return op == 4'd13 || op == 4'd15;
`else
    return op == 4'd13;
`endif
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op,
                                           input logic [W-1:0] a, b);
    int unsigned s;
    s = b % W;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return (a < b) ? 1 : 0;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  return a << s;
      4'd9:  return a >> s;
      4'd10: return $signed(a) >>> s;
      default: return '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b);
    exp_t e;
    logic [2*W-1:0] p;
    bit lng;
    lng = 0;
    if (is_mul(op)) begin
      p = {32'b0, a} * {32'b0, b};
`ifdef SIGNED_MULDIV_EN
      if (op == 4'd14) p = longint'($signed(a)) * longint'($signed(b));
`endif
      m_hi = p[2*W-1:W];
      m_lo = p[W-1:0];
      m_dz = 0;
      lng = 1;
    end else if (is_div(op)) begin
      m_dz = 0;
      if (b == 0) begin
        m_lo = '1;
        m_hi = a;
        m_dz = 1;
      end else begin
        lng = 1;
        m_lo = a / b;
        m_hi = a % b;
`ifdef SIGNED_MULDIV_EN
        if (op == 4'd15) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            m_lo = a;
            m_hi = 0;
          end else begin
            m_lo = $signed(a) / $signed(b);
            m_hi = $signed(a) % $signed(b);
          end
        end
`endif
      end
    end else begin
      m_res = alu_ref(op, a, b);
      m_dz = 0;
    end
    e.res = m_res;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.dz  = m_dz;
    e.cyc = cyc + 1 + (lng ? W : 0);
    q.push_back(e);
    Start = 1'b1;
    SrcA = a;
    SrcB = b;
    ALUControl = op;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL busy_timeout: got Busy=1 after %0d cycles expected 0", n);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && Done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got Done=1 at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("alu_result", 64'(ALUResult), 64'(e.res));
          check("zero", 64'(Zero), 64'(e.res == 0));
          check("hi", 64'(Hi), 64'(e.hi));
          check("lo", 64'(Lo), 64'(e.lo));
          check("divzero", 64'(DivZero), 64'(e.dz));
          check("busy_at_done", 64'(Busy), 64'(0));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_result"}, 64'(ALUResult), 64'(0));
    check({tag, "_zero"}, 64'(Zero), 64'(1));
    check({tag, "_hi"}, 64'(Hi), 64'(0));
    check({tag, "_lo"}, 64'(Lo), 64'(0));
    check({tag, "_busy"}, 64'(Busy), 64'(0));
    check({tag, "_done"}, 64'(Done), 64'(0));
    check({tag, "_divzero"}, 64'(DivZero), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h80000000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : stim
    int n;
    logic [3:0] op;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(4'd2, 32'hFFFFFFFF, 32'd1);
    issue(4'd7, 32'h80000000, 32'd1);
    check("slt_direct", 64'(ALUResult), 64'(1));
    issue(4'd5, 32'h80000000, 32'd1);
    check("sltu_direct", 64'(ALUResult), 64'(0));
    issue(4'd10, 32'h80000000, 32'd4);
    check("sra_direct", 64'(ALUResult), 64'(32'hF8000000));

    issue(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    check("multu_busy_cycles", 64'(n), 64'(32));
    check("multu_hi_direct", 64'(Hi), 64'(32'hFFFFFFFE));
    check("multu_lo_direct", 64'(Lo), 64'(32'h00000001));

    issue(4'd13, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo_direct", 64'(Lo), 64'(14));
    check("divu_hi_direct", 64'(Hi), 64'(2));

    issue(4'd13, 32'd5, 32'd0);
    check("divu0_divzero_direct", 64'(DivZero), 64'(1));
    issue(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0);

    issue(4'd12, 32'd1234, 32'd5678);
    repeat (5) @(posedge clk);
    #1;
    Start = 1'b1;
    ALUControl = 4'd2;
    SrcA = 32'd1;
    SrcB = 32'd1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_idle(n);
    check("ignored_start_lo", 64'(Lo), 64'(1234 * 5678));

    issue(4'd12, 32'hDEADBEEF, 32'h12345678);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    q.delete();
    m_res = '0;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue(4'd12, 32'd3, 32'd7);
    wait_idle(n);

`ifdef SIGNED_MULDIV_EN
    issue(4'd15, -32'sd7, 32'd2);
    wait_idle(n);
    issue(4'd14, -32'sd3, 32'd4);
    wait_idle(n);
    issue(4'd15, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
`endif

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, pick(), pick());
      wait_idle(n);
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
